// File: rtl/activation_buffer_arb.sv
// Two-port arbiter in front of the banked activation SRAM (narrow lane-group port 1, full-width port 2).
// Latency: requests and writes are issued in the grant cycle; read data returns rdLatency cycles after the grant.
// Backpressure: pN_ready_o is high only when port N is granted; read returns are pulses and cannot be stalled.
module activation_buffer_arb #(
    parameter int addrWidth   = 18,
    parameter int dataSize    = 8,
    parameter int numBanks    = 32,
    parameter int narrowBanks = 4,
    parameter int rdLatency   = 1,
    parameter int starveLimit = 4
) (
    input  logic                              clk,
    input  logic                              nrst,

    input  logic                              p1_valid_i,
    output logic                              p1_ready_o,
    input  logic                              p1_we_i,
    input  logic [addrWidth-1:0]              p1_addr_i,
    input  logic [narrowBanks*dataSize-1:0]   p1_wdata_i,
    output logic                              p1_rvalid_o,
    output logic [narrowBanks*dataSize-1:0]   p1_rdata_o,

    input  logic                              p2_valid_i,
    output logic                              p2_ready_o,
    input  logic                              p2_we_i,
    input  logic [addrWidth-1:0]              p2_addr_i,
    input  logic [numBanks*dataSize-1:0]      p2_wdata_i,
    output logic                              p2_rvalid_o,
    output logic [numBanks*dataSize-1:0]      p2_rdata_o,

    output logic [addrWidth-1:0]              sram_addr_o,
    output logic                              sram_wr_en_o,
    output logic [numBanks-1:0]               sram_bank_mask_o,
    output logic [numBanks*dataSize-1:0]      sram_wr_data_o,
    input  logic [numBanks*dataSize-1:0]      sram_rd_data_i
);

    localparam int W1    = narrowBanks * dataSize;
    localparam int W2    = numBanks * dataSize;
    localparam int G     = numBanks / narrowBanks;
    localparam int gBits = $clog2(G);
    localparam int CntW  = $clog2(starveLimit + 1);

    // Bank enables for a narrow access to lane group 0; shifted up to the addressed group.
    localparam logic [numBanks-1:0] NARROW_MASK = {{(numBanks - narrowBanks){1'b0}}, {narrowBanks{1'b1}}};

    // Tag carried alongside each granted read until its data comes back.
    typedef struct packed {
        logic             vld;
        logic             port;   // 0 = port 1, 1 = port 2
        logic [gBits-1:0] g;      // lane group of a narrow read
    } rd_tag_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            rr_ptr_q, rr_ptr_d;          // 0 = port 1 wins next contested grant
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    rd_tag_t         rd_pipe_q [rdLatency];
    rd_tag_t         rd_pipe_d [rdLatency];
    logic [W1-1:0]   p1_rdata_q, p1_rdata_d;
    logic [W2-1:0]   p2_rdata_q, p2_rdata_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic rd1, wr1, rd2, wr2;
    logic any_rd, any_wr;
    logic force_wr, wr_class;
    logic elig1, elig2;
    logic gnt1, gnt2;
    logic wr_granted;
    logic [gBits-1:0] p1_g;

    assign p1_g = p1_addr_i[gBits-1:0];

    // Classify requests, pick the winning class, then round-robin inside it.
    always_comb begin
        rd1      = p1_valid_i & ~p1_we_i;
        wr1      = p1_valid_i &  p1_we_i;
        rd2      = p2_valid_i & ~p2_we_i;
        wr2      = p2_valid_i &  p2_we_i;
        any_rd   = rd1 | rd2;
        any_wr   = wr1 | wr2;
        force_wr = (starve_cnt_q == CntW'(starveLimit));
        // Writes only win when no read is pending or a write has starved long enough.
        wr_class = any_wr & (force_wr | ~any_rd);
        elig1    = wr_class ? wr1 : rd1;
        elig2    = wr_class ? wr2 : rd2;

        gnt1     = 1'b0;
        gnt2     = 1'b0;
        rr_ptr_d = rr_ptr_q;
        // Gate with nrst so nothing is granted while the block is held in reset.
        if (nrst) begin
            if (elig1 && elig2) begin
                if (rr_ptr_q == 1'b0) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt2 = 1'b1;
                end
                rr_ptr_d = ~rr_ptr_q;
            end else if (elig1) begin
                gnt1 = 1'b1;
            end else if (elig2) begin
                gnt2 = 1'b1;
            end
        end
        wr_granted = (gnt1 & p1_we_i) | (gnt2 & p2_we_i);
    end

    // Count cycles a pending write loses; saturate so force_wr holds until a write wins.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!any_wr || wr_granted) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CntW'(starveLimit)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    // ------------------------------------------------------------------
    // SRAM command
    // ------------------------------------------------------------------
    // Drive the macro from the granted port; all-zero command when idle.
    always_comb begin
        p1_ready_o       = gnt1;
        p2_ready_o       = gnt2;
        sram_addr_o      = '0;
        sram_wr_en_o     = 1'b0;
        sram_bank_mask_o = '0;
        sram_wr_data_o   = '0;
        if (gnt1) begin
            sram_addr_o      = p1_addr_i >> gBits;
            sram_wr_en_o     = p1_we_i;
            sram_bank_mask_o = NARROW_MASK << (int'(p1_g) * narrowBanks);
            if (p1_we_i) begin
                sram_wr_data_o = {{(W2 - W1){1'b0}}, p1_wdata_i} << (int'(p1_g) * W1);
            end
        end else if (gnt2) begin
            sram_addr_o      = p2_addr_i;
            sram_wr_en_o     = p2_we_i;
            sram_bank_mask_o = '1;
            if (p2_we_i) begin
                sram_wr_data_o = p2_wdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline
    // ------------------------------------------------------------------
    // Push a tag per read grant; the last stage lines up with SRAM read data.
    always_comb begin
        rd_pipe_d[0].vld  = (gnt1 & ~p1_we_i) | (gnt2 & ~p2_we_i);
        rd_pipe_d[0].port = gnt2;
        rd_pipe_d[0].g    = gnt1 ? p1_g : '0;
        for (int i = 1; i < rdLatency; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    rd_tag_t rd_out;
    assign rd_out = rd_pipe_q[rdLatency-1];

    // Steer returning data to its port; rdata holds its last value between pulses.
    always_comb begin
        p1_rvalid_o = rd_out.vld & ~rd_out.port;
        p2_rvalid_o = rd_out.vld &  rd_out.port;
        p1_rdata_o  = p1_rvalid_o ? sram_rd_data_i[int'(rd_out.g) * W1 +: W1] : p1_rdata_q;
        p2_rdata_o  = p2_rvalid_o ? sram_rd_data_i : p2_rdata_q;
        p1_rdata_d  = p1_rdata_o;
        p2_rdata_d  = p2_rdata_o;
    end

    // State registers; reset drops any reads still in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr_q     <= 1'b0;
            starve_cnt_q <= '0;
            p1_rdata_q   <= '0;
            p2_rdata_q   <= '0;
            for (int i = 0; i < rdLatency; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            p1_rdata_q   <= p1_rdata_d;
            p2_rdata_q   <= p2_rdata_d;
            for (int i = 0; i < rdLatency; i++) begin
                rd_pipe_q[i] <= rd_pipe_d[i];
            end
        end
    end

endmodule

// File: tb/tb_activation_buffer_arb.sv
// Directed bench for activation_buffer_arb with a small behavioural SRAM (1-cycle read latency).
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
// Expected values are hand-computed constants in each step.
module tb_activation_buffer_arb;

    localparam int AW = 18;
    localparam int W1 = 32;
    localparam int W2 = 256;

    logic          clk;
    logic          nrst;
    logic          p1_valid_i, p1_ready_o, p1_we_i, p1_rvalid_o;
    logic [AW-1:0] p1_addr_i;
    logic [W1-1:0] p1_wdata_i, p1_rdata_o;
    logic          p2_valid_i, p2_ready_o, p2_we_i, p2_rvalid_o;
    logic [AW-1:0] p2_addr_i;
    logic [W2-1:0] p2_wdata_i, p2_rdata_o;
    logic [AW-1:0] sram_addr_o;
    logic          sram_wr_en_o;
    logic [31:0]   sram_bank_mask_o;
    logic [W2-1:0] sram_wr_data_o;
    logic [W2-1:0] sram_rd_data_i;

    int checks = 0;
    int errors = 0;

    activation_buffer_arb #(
        .addrWidth(18), .dataSize(8), .numBanks(32), .narrowBanks(4),
        .rdLatency(1), .starveLimit(4)
    ) dut (
        .clk(clk), .nrst(nrst),
        .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o), .p1_we_i(p1_we_i),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
        .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .p2_valid_i(p2_valid_i), .p2_ready_o(p2_ready_o), .p2_we_i(p2_we_i),
        .p2_addr_i(p2_addr_i), .p2_wdata_i(p2_wdata_i),
        .p2_rvalid_o(p2_rvalid_o), .p2_rdata_o(p2_rdata_o),
        .sram_addr_o(sram_addr_o), .sram_wr_en_o(sram_wr_en_o),
        .sram_bank_mask_o(sram_bank_mask_o), .sram_wr_data_o(sram_wr_data_o),
        .sram_rd_data_i(sram_rd_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-masked writes, registered reads, 64 rows.
    logic          mem_clr;
    logic [W2-1:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int r = 0; r < 64; r++) mem[r] <= '0;
            sram_rd_data_i <= '0;
        end else if (sram_bank_mask_o != 32'h0) begin
            if (sram_wr_en_o) begin
                for (int b = 0; b < 32; b++)
                    if (sram_bank_mask_o[b]) mem[sram_addr_o[5:0]][b*8 +: 8] <= sram_wr_data_o[b*8 +: 8];
            end else begin
                sram_rd_data_i <= mem[sram_addr_o[5:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [W2-1:0] obs, input logic [W2-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p1_valid_i = 0; p1_we_i = 0; p1_addr_i = '0; p1_wdata_i = '0;
        p2_valid_i = 0; p2_we_i = 0; p2_addr_i = '0; p2_wdata_i = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_p1_ready"}, W2'(p1_ready_o), '0);
        chk({tag, "_p2_ready"}, W2'(p2_ready_o), '0);
        chk({tag, "_wr_en"},    W2'(sram_wr_en_o), '0);
        chk({tag, "_mask"},     W2'(sram_bank_mask_o), '0);
        chk({tag, "_addr"},     W2'(sram_addr_o), '0);
        chk({tag, "_wr_data"},  sram_wr_data_o, '0);
        chk({tag, "_p1_rvalid"}, W2'(p1_rvalid_o), '0);
        chk({tag, "_p2_rvalid"}, W2'(p2_rvalid_o), '0);
        chk({tag, "_p1_rdata"}, W2'(p1_rdata_o), '0);
        chk({tag, "_p2_rdata"}, p2_rdata_o, '0);
    endtask

    initial begin
        logic [W2-1:0] a5_all;
        logic [W2-1:0] beef_hi;
        a5_all  = {32{8'hA5}};
        beef_hi = 256'hDEADBEEF << 96;

        // Reset with a request pending: every output must stay 0.
        idle();
        mem_clr = 1'b1;
        nrst    = 1'b0;
        p1_valid_i = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        mem_clr = 1'b0;
        nrst    = 1'b1;

        // Port 2 full-width write to 0x10.
        idle();
        p2_valid_i = 1; p2_we_i = 1; p2_addr_i = 18'h10; p2_wdata_i = a5_all;
        #1;
        chk("p2wr_ready", W2'(p2_ready_o), 1);
        chk("p2wr_p1_ready", W2'(p1_ready_o), 0);
        chk("p2wr_wr_en", W2'(sram_wr_en_o), 1);
        chk("p2wr_mask", W2'(sram_bank_mask_o), 256'hFFFFFFFF);
        chk("p2wr_addr", W2'(sram_addr_o), 256'h10);
        chk("p2wr_data", sram_wr_data_o, a5_all);
        next_cycle();

        // Port 2 read back of 0x10.
        idle();
        p2_valid_i = 1; p2_addr_i = 18'h10;
        #1;
        chk("p2rd_ready", W2'(p2_ready_o), 1);
        chk("p2rd_wr_en", W2'(sram_wr_en_o), 0);
        chk("p2rd_mask", W2'(sram_bank_mask_o), 256'hFFFFFFFF);
        next_cycle();

        // Return one cycle after the grant; idle command outputs.
        idle();
        #1;
        chk("p2rd_rvalid", W2'(p2_rvalid_o), 1);
        chk("p2rd_rdata", p2_rdata_o, a5_all);
        chk("p2rd_p1_rvalid", W2'(p1_rvalid_o), 0);
        chk("idle_mask", W2'(sram_bank_mask_o), 0);
        chk("idle_addr", W2'(sram_addr_o), 0);
        chk("idle_wr_en", W2'(sram_wr_en_o), 0);
        next_cycle();

        // Pulse is over, data holds; port 1 narrow write to 0x0B (g=3, row 1).
        p1_valid_i = 1; p1_we_i = 1; p1_addr_i = 18'h0B; p1_wdata_i = 32'hDEADBEEF;
        #1;
        chk("rvalid_pulse_end", W2'(p2_rvalid_o), 0);
        chk("p2_rdata_hold", p2_rdata_o, a5_all);
        chk("p1wr_ready", W2'(p1_ready_o), 1);
        chk("p1wr_mask", W2'(sram_bank_mask_o), 256'h0000F000);
        chk("p1wr_addr", W2'(sram_addr_o), 256'h1);
        chk("p1wr_data", sram_wr_data_o, beef_hi);
        next_cycle();

        // Port 1 read of 0x0B.
        idle();
        p1_valid_i = 1; p1_addr_i = 18'h0B;
        #1;
        chk("p1rd_ready", W2'(p1_ready_o), 1);
        chk("p1rd_wr_en", W2'(sram_wr_en_o), 0);
        chk("p1rd_mask", W2'(sram_bank_mask_o), 256'h0000F000);
        next_cycle();

        // Port 2 read of row 1 while port 1 data returns.
        idle();
        p2_valid_i = 1; p2_addr_i = 18'h1;
        #1;
        chk("p1rd_rvalid", W2'(p1_rvalid_o), 1);
        chk("p1rd_rdata", W2'(p1_rdata_o), 256'hDEADBEEF);
        chk("p2row1_ready", W2'(p2_ready_o), 1);
        next_cycle();

        idle();
        #1;
        chk("p2row1_rvalid", W2'(p2_rvalid_o), 1);
        chk("p2row1_rdata", p2_rdata_o, beef_hi);
        next_cycle();

        // Both ports read for 4 cycles: grants alternate 1,2,1,2 and returns follow.
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) begin
                p1_valid_i = 1; p1_addr_i = 18'h0;
                p2_valid_i = 1; p2_addr_i = 18'h10;
            end
            #1;
            if (i < 4) begin
                chk($sformatf("rr_p1_ready_%0d", i), W2'(p1_ready_o), W2'(i % 2 == 0));
                chk($sformatf("rr_p2_ready_%0d", i), W2'(p2_ready_o), W2'(i % 2 == 1));
            end
            if (i > 0) begin
                chk($sformatf("rr_p1_rvalid_%0d", i), W2'(p1_rvalid_o), W2'((i - 1) % 2 == 0));
                chk($sformatf("rr_p2_rvalid_%0d", i), W2'(p2_rvalid_o), W2'((i - 1) % 2 == 1));
            end
            next_cycle();
        end

        // Port 2 write held against continuous port 1 reads: blocked 4 cycles, wins the 5th.
        for (int k = 1; k <= 6; k++) begin
            idle();
            p1_valid_i = 1; p1_addr_i = 18'h0;
            if (k <= 5) begin
                p2_valid_i = 1; p2_we_i = 1; p2_addr_i = 18'h20; p2_wdata_i = {32{8'h3C}};
            end
            #1;
            if (k <= 4) begin
                chk($sformatf("starve_p1_ready_%0d", k), W2'(p1_ready_o), 1);
                chk($sformatf("starve_p2_ready_%0d", k), W2'(p2_ready_o), 0);
            end else if (k == 5) begin
                chk("starve_cnt_sat", W2'(dut.starve_cnt_q), 4);
                chk("starve_p2_ready_5", W2'(p2_ready_o), 1);
                chk("starve_p1_ready_5", W2'(p1_ready_o), 0);
                chk("starve_wr_en_5", W2'(sram_wr_en_o), 1);
            end else begin
                chk("starve_cnt_clear", W2'(dut.starve_cnt_q), 0);
                chk("starve_p1_ready_6", W2'(p1_ready_o), 1);
            end
            next_cycle();
        end

        // Simultaneous port 1 write and port 2 read: read first, write next cycle.
        idle();
        p1_valid_i = 1; p1_we_i = 1; p1_addr_i = 18'h05; p1_wdata_i = 32'h12345678;
        p2_valid_i = 1; p2_addr_i = 18'h0;
        #1;
        chk("mix_p2_ready", W2'(p2_ready_o), 1);
        chk("mix_p1_ready", W2'(p1_ready_o), 0);
        next_cycle();
        p2_valid_i = 0;
        #1;
        chk("mix_p1_ready_next", W2'(p1_ready_o), 1);
        chk("mix_wr_en_next", W2'(sram_wr_en_o), 1);
        chk("mix_mask_next", W2'(sram_bank_mask_o), 256'h00F00000);
        chk("mix_data_next", sram_wr_data_o, 256'h12345678 << 160);
        next_cycle();

        // Contested read pair moves rr_ptr to port 2.
        idle();
        p1_valid_i = 1; p1_addr_i = 18'h0B;
        p2_valid_i = 1; p2_addr_i = 18'h10;
        #1;
        chk("pre_rst_p1_ready", W2'(p1_ready_o), 1);
        next_cycle();
        p1_valid_i = 0;
        #1;
        chk("pre_rst_p2_ready", W2'(p2_ready_o), 1);
        chk("pre_rst_p1_rvalid", W2'(p1_rvalid_o), 1);
        chk("pre_rst_p1_rdata", W2'(p1_rdata_o), 256'hDEADBEEF);

        // Reset with the port 2 read in flight.
        #1;
        nrst = 1'b0;
        p1_valid_i = 1;
        #1;
        chk_all_zero("midrst");
        next_cycle();
        chk("midrst_p2_rvalid_held", W2'(p2_rvalid_o), 0);

        // Release: rr_ptr is back at port 1 and the dropped read never returns.
        nrst = 1'b1;
        idle();
        p1_valid_i = 1; p1_addr_i = 18'h0;
        p2_valid_i = 1; p2_addr_i = 18'h0;
        #1;
        chk("post_rst_p1_ready", W2'(p1_ready_o), 1);
        chk("post_rst_p2_ready", W2'(p2_ready_o), 0);
        chk("post_rst_p2_rvalid", W2'(p2_rvalid_o), 0);
        next_cycle();
        p1_valid_i = 0;
        #1;
        chk("post_rst_p2_ready_next", W2'(p2_ready_o), 1);
        chk("post_rst_p1_rvalid", W2'(p1_rvalid_o), 1);
        next_cycle();
        idle();
        #1;
        chk("post_rst_p2_rvalid_next", W2'(p2_rvalid_o), 1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/activation_buffer_arb.md
Name: activation_buffer_arb

Overview:
- Two-port arbitrated front end for the banked activation SRAM (sram_32bank_8b-style macro: per-bank mask, shared address, fixed read latency).
- Port 1 is a narrow lane-group port; port 2 is a full-width port. Both ports use valid/ready request handshakes and a tagged read-return pipeline.
- Read-over-write priority with a write-starvation guard. Round-robin between ports within the same class.
- Sits between the accelerator datapath / CSR-side loader and the SRAM macro; replaces the purely combinational wrapper.

Parameters:
- addrWidth, 18, port address width.
- dataSize, 8, bits per bank.
- numBanks, 32, SRAM banks; wide width W2 = numBanks*dataSize.
- narrowBanks, 4, banks per narrow access; narrow width W1 = narrowBanks*dataSize. numBanks/narrowBanks must be a power of 2; G = numBanks/narrowBanks, gBits = log2(G).
- rdLatency, 1, SRAM read latency in cycles (>=1).
- starveLimit, 4, consecutive lost cycles before a pending write is forced through (>=1).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- p1_valid_i  in  1  port 1 request valid
- p1_ready_o  out  1  port 1 request accepted this cycle
- p1_we_i  in  1  1 = write, 0 = read
- p1_addr_i  in  addrWidth  narrow word address
- p1_wdata_i  in  W1  narrow write data
- p1_rvalid_o  out  1  port 1 read data valid
- p1_rdata_o  out  W1  port 1 read data
- p2_valid_i, p2_ready_o, p2_we_i, p2_addr_i (addrWidth), p2_wdata_i (W2), p2_rvalid_o, p2_rdata_o (W2)  same semantics, wide port
- sram_addr_o  out  addrWidth  SRAM row address
- sram_wr_en_o  out  1  SRAM write enable
- sram_bank_mask_o  out  numBanks  SRAM bank enable mask
- sram_wr_data_o  out  W2  SRAM write data
- sram_rd_data_i  in  W2  SRAM read data, valid rdLatency cycles after a read command

Behaviour:
- Clocking/reset: one clock, clk. Reset nrst is asynchronous, active-low.
- At most one grant per cycle. pN_ready_o is combinational: high only in the cycle port N is granted. A request transfers when valid && ready. Requesters hold valid, addr, we and wdata stable until ready.
- Class priority: pending reads beat pending writes. Exception: when force_wr = 1, writes beat reads.
- starve_cnt: increments (saturating at starveLimit) each cycle a write is valid but not granted. Clears on any write grant or when no write is pending. force_wr = (starve_cnt == starveLimit).
- Within a class, if both ports are eligible, round-robin: rr_ptr starts at port 1 after reset and flips to the other port after each contested grant. Uncontested grants do not move rr_ptr.
- Port 1 mapping:
  - g = p1_addr_i[gBits-1:0]; sram_addr_o = p1_addr_i >> gBits.
  - sram_bank_mask_o = {narrowBanks{1'b1}} << (g*narrowBanks).
  - Write data is placed at bits [g*W1 +: W1]; all other bits are 0.
- Port 2 mapping: sram_addr_o = p2_addr_i; mask all ones; data passed through.
- Idle outputs: sram_wr_en_o = 0, mask = 0, addr = 0, wr_data = 0.
- Read return:
  - Each read grant pushes {valid, port, g} into an rdLatency-deep shift register.
  - At the output stage: if port == 1, drive p1_rvalid_o = 1 and p1_rdata_o = sram_rd_data_i[g*W1 +: W1]. If port == 2, drive p2_rvalid_o = 1 and p2_rdata_o = sram_rd_data_i.
  - rvalid is a one-cycle pulse with no backpressure. Read data holds its last value when rvalid is low.
  - Back-to-back reads give one return per cycle, in grant order.
- Write latency: committed in the grant cycle. No write acknowledge beyond ready.
- Same-address hazard: a read granted in the cycle after a write to the same row returns the new data. This requires an SRAM macro with that property; the arbiter does not bypass.
- Reset, including mid-operation:
  - All outputs go to 0. rr_ptr goes to port 1, starve_cnt to 0.
  - The read pipeline is cleared; in-flight reads are dropped and never returned.

Test Plan:
- Port 2 writes addr 0x10, data {32{8'hA5}}, then reads 0x10 -> write cycle: mask 0xFFFFFFFF, wr_en = 1. Read: p2_rvalid_o pulses 1 cycle after grant with all bytes 0xA5.
- Port 1 writes addr 0x0B (g = 3, row 1), data 0xDEADBEEF -> mask 0x0000F000, row 1, wr_data bits [127:96] = 0xDEADBEEF, all other bits 0. A later port 1 read of 0x0B returns 0xDEADBEEF; port 2 read of row 1 shows it in bytes 12-15.
- Port 1 read and port 2 read held valid for 4 cycles -> grants alternate 1,2,1,2. rvalids alternate in the same order, each 1 cycle after its grant.
- Port 2 write held while port 1 reads continuously (starveLimit = 4) -> write is blocked for 4 cycles and granted in cycle 5. starve_cnt returns to 0.
- Assert nrst low with 1 read in flight -> no rvalid appears after reset release; all outputs are 0 during reset.
- Simultaneous port 1 write and port 2 read with no starvation -> read granted first, write granted the next cycle.
